// File: rtl/llm_staged_if.sv
// llm_staged_if: threat indicators in, controller state/enables out.
// The controller uses the slave modport; the driver of the indicators
// (upstream logic or a bench) uses the master modport.
interface llm_staged_if #(
    parameter int NUM_STAGES     = 3,
    parameter int TIMER_W        = 6,
    parameter int MAX_DECEPTIONS = 3
);
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CNT_W   = ($clog2(MAX_DECEPTIONS + 1) > 0) ? $clog2(MAX_DECEPTIONS + 1) : 1;

    logic                  green;
    logic                  red;
    logic                  yellow;
    logic [2:0]            mode;
    logic [STAGE_W-1:0]    stage;
    logic [NUM_STAGES-1:0] attack_en;
    logic                  expansion_out;
    logic                  deception_out;
    logic [CNT_W-1:0]      deception_cnt;
    logic [TIMER_W-1:0]    timer;

    modport master (
        output green, red, yellow,
        input  mode, stage, attack_en, expansion_out, deception_out, deception_cnt, timer
    );

    modport slave (
        input  green, red, yellow,
        output mode, stage, attack_en, expansion_out, deception_out, deception_cnt, timer
    );
endinterface

// File: rtl/llm_staged.sv
// llm_staged: lay-low / N-stage attack / expansion sequencer with yellow
// step-back, saturating state timer and a deception budget escalating to FAIL.
// Optional feature macro: LLM_RECOVER_EN (yellow-held recovery out of FAIL).
// All outputs are decoded from registered state only.
module llm_staged #(
    parameter int NUM_STAGES     = 3,
    parameter int TIMER_W        = 6,
    parameter int LOW_DWELL      = 20,
    parameter int STAGE_DWELL    = 20,
    parameter int LAST_DWELL     = 10,
    parameter int DECEPT_LEN     = 15,
    parameter int MAX_DECEPTIONS = 3,
    parameter int RECOVER_LEN    = 8
) (
    input  logic      clock,
    input  logic      reset_n,
    llm_staged_if.slave bus
);
    localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CNT_W   = ($clog2(MAX_DECEPTIONS + 1) > 0) ? $clog2(MAX_DECEPTIONS + 1) : 1;
    localparam int TMAX    = (1 << TIMER_W) - 1;

    localparam logic [TIMER_W-1:0] LOW_T    = TIMER_W'(LOW_DWELL);
    localparam logic [TIMER_W-1:0] STAGE_T  = TIMER_W'(STAGE_DWELL);
    localparam logic [TIMER_W-1:0] LAST_T   = TIMER_W'(LAST_DWELL);
    localparam logic [TIMER_W-1:0] DECEPT_T = TIMER_W'(DECEPT_LEN);
    localparam logic [TIMER_W-1:0] ONE_T    = TIMER_W'(1);
    localparam logic [STAGE_W-1:0] LAST_STG = STAGE_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_DECEPTIONS);

    // Build-time parameter checks: every dwell must be reachable by the timer.
    // RECOVER_LEN is range-checked even when recovery is not built so the
    // parameter set stays valid if the feature is switched on later.
    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
            $error("llm_staged: NUM_STAGES must be 1..8");
        end
        if (MAX_DECEPTIONS < 1) begin : g_bad_max
            $error("llm_staged: MAX_DECEPTIONS must be >= 1");
        end
        if (LOW_DWELL > TMAX || STAGE_DWELL > TMAX || LAST_DWELL > TMAX ||
            DECEPT_LEN > TMAX || RECOVER_LEN > TMAX) begin : g_bad_dwell
            $error("llm_staged: a dwell exceeds the timer range");
        end
    endgenerate

    typedef enum logic [2:0] {
        LAY_LOW   = 3'd0,
        ATTACK    = 3'd1,
        DECEPTION = 3'd2,
        FAIL      = 3'd3,
        EXPANSION = 3'd4
    } mode_t;

    mode_t              mode_q,  mode_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               restart;
    logic [TIMER_W-1:0] dwell;

    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == MAX_CNT) ? c : c + 1'b1;
    endfunction

    // State register: synchronous active-low reset overrides every transition.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode_q  <= LAY_LOW;
            stage_q <= '0;
            timer_q <= ONE_T;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            stage_q <= stage_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: red > yellow > green, dwell tests use the pre-edge timer.
    always_comb begin
        mode_d  = mode_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        restart = 1'b0;
        dwell   = (stage_q == LAST_STG) ? LAST_T : STAGE_T;
        case (mode_q)
            LAY_LOW: begin
                if (bus.red) begin
                    mode_d = DECEPTION;
                end else if (bus.yellow) begin
                    restart = 1'b1;
                end else if (bus.green && timer_q >= LOW_T) begin
                    mode_d  = ATTACK;
                    stage_d = '0;
                end
            end
            ATTACK: begin
                if (bus.red) begin
                    mode_d  = DECEPTION;
                    stage_d = '0;
                end else if (bus.yellow) begin
                    if (stage_q == '0) begin
                        mode_d = LAY_LOW;
                    end else begin
                        stage_d = stage_q - 1'b1;
                    end
                end else if (bus.green && timer_q >= dwell) begin
                    if (stage_q == LAST_STG) begin
                        mode_d  = EXPANSION;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            DECEPTION: begin
                // Inputs only matter once the deception window has run out.
                if (timer_q >= DECEPT_T) begin
                    if (bus.red || cnt_q == MAX_CNT) begin
                        mode_d = FAIL;
                    end else begin
                        mode_d = LAY_LOW;
                    end
                end
            end
            FAIL: begin
`ifdef LLM_RECOVER_EN
                // Recovery needs yellow held continuously for RECOVER_LEN cycles.
                if (!bus.yellow) begin
                    restart = 1'b1;
                end else if (timer_q >= TIMER_W'(RECOVER_LEN)) begin
                    mode_d = LAY_LOW;
                    cnt_d  = '0;
                end
`else
                mode_d = FAIL;
`endif
            end
            EXPANSION: begin
                mode_d = EXPANSION;
            end
            default: begin
                mode_d  = LAY_LOW;
                stage_d = '0;
            end
        endcase

        if (mode_d == DECEPTION && mode_q != DECEPTION) begin
            cnt_d = cnt_inc(cnt_q);
        end

        // Any change of (mode, stage), including a stage step, restarts the timer.
        if (restart || mode_d != mode_q || stage_d != stage_q) begin
            timer_d = ONE_T;
        end else begin
            timer_d = timer_inc(timer_q);
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        bus.mode          = mode_q;
        bus.stage         = stage_q;
        bus.expansion_out = (mode_q == EXPANSION);
        bus.deception_out = (mode_q == DECEPTION) || (mode_q == FAIL);
        bus.deception_cnt = cnt_q;
        bus.timer         = timer_q;
        bus.attack_en     = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bus.attack_en[i] = (mode_q == EXPANSION) ||
                               (mode_q == ATTACK && i <= int'(stage_q));
        end
    end
endmodule
